// File: rtl/axis_serdes_pkg.sv
// Shared types and constants for the SERDES read-side AXI-Stream path.
// Holds skid buffer sizing and the packet counter width.
package axis_serdes_pkg;

    localparam int SKID_DEPTH = 3;
    localparam int PKT_CNT_W  = 16;

    typedef logic [1:0] skid_ptr_t;
    typedef logic [1:0] skid_occ_t;

    // Circular pointer step; the buffer is not a power of two deep.
    function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Three-entry circular skid buffer absorbing FIFO read latency.
// Write on wr_en_i, pop on pop_i, head entry always visible.
module axis_skid_buf
    import axis_serdes_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [1:0]   occ_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [SKID_DEPTH];
    skid_ptr_t    rd_q, rd_d;
    skid_ptr_t    wr_q, wr_d;
    skid_occ_t    occ_q, occ_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        occ_d = occ_q;
        if (wr_en_i) wr_d = ptr_inc(wr_q);
        if (pop_i)   rd_d = ptr_inc(rd_q);
        case ({wr_en_i, pop_i})
            2'b10:   occ_d = occ_q + skid_occ_t'(1);
            2'b01:   occ_d = occ_q - skid_occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
        end
    end

    // Storage is left unreset; stale contents are never presented as valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !rst_i) mem_q[wr_q] <= wr_data_i;
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_q];

endmodule

// File: rtl/axis_fifo_reader.sv
// Drains a one-cycle-latency FIFO read port into an AXI-Stream master.
// Read issue depends only on registered state and i_rempty.
module axis_fifo_reader
    import axis_serdes_pkg::*;
#(
    parameter int LOGIC_SIZE = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_rr,
    input  logic [LOGIC_SIZE-1:0] i_rdata,
    input  logic                  i_rempty,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic [LOGIC_SIZE-1:0] o_tdata,
    output logic                  o_tlast,
    output logic [PKT_CNT_W-1:0]  o_pkt_cnt
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic                 pend_q, pend_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
    logic [1:0]           occ;
    logic [2:0]           fill;
    logic                 pop;

    axis_skid_buf #(
        .W(LOGIC_SIZE)
    ) u_skid (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .wr_en_i  (pend_q),
        .wr_data_i(i_rdata),
        .pop_i    (pop),
        .occ_o    (occ),
        .head_o   (o_tdata)
    );

    // Count the in-flight word so a stall can never overflow the buffer.
    assign fill     = {1'b0, occ} + {2'b00, pend_q};
    assign o_rr     = !i_rst && !i_rempty && (fill < 3'd3);
    assign o_tvalid = !i_rst && (occ != 2'd0);
    assign o_tlast  = o_tvalid && (beat_q == BEAT_LAST);
    assign pop      = o_tvalid && i_tready;

    always_comb begin
        pend_d = o_rr;
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            if (o_tlast) begin
                beat_d = '0;
                pkt_d  = pkt_q + PKT_CNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_q <= 1'b0;
            beat_q <= '0;
            pkt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            beat_q <= beat_d;
            pkt_q  <= pkt_d;
        end
    end

    assign o_pkt_cnt = pkt_q;

endmodule
